// File: rtl/antirrebote_pkg.sv
// Shared constants and helpers for the button debouncer family.
package antirrebote_pkg;

  localparam int CLK_HZ              = 50_000_000;
  localparam int DEBOUNCE_CYCLES_DEF = 8;

  // Returns the stability counter width needed to count a debounce time
  // given in microseconds at CLK_HZ.
  function automatic int cnt_w_from_us(input int us);
    int cycles;
    cycles = (CLK_HZ / 1_000_000) * us;
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Generic two-flop synchroniser with synchronous active-high reset.
module sincronizador_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  // Two-stage chain; only q is safe to use in the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/boton_antirrebote.sv
// Push-button debouncer: synchroniser, stability filter, press counter.
module boton_antirrebote
  import antirrebote_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  output logic       out,
  output logic [3:0] count_out
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync2;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             out_nxt;
  logic             rise;

  sincronizador_2ff #(.W(1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (sync2)
  );

  // Stability filter: count consecutive samples that disagree with out,
  // flip out once the run reaches DEBOUNCE_CYCLES; any agreement restarts.
  always_comb begin
    cnt_nxt = '0;
    out_nxt = out;
    if (sync2 != out) begin
      if (cnt == LAST) begin
        out_nxt = sync2;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // A press is a 0->1 change of the debounced level.
  always_comb rise = out_nxt & ~out;

  // Filter state, debounced level and modulo-16 press counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      out       <= 1'b0;
      count_out <= 4'd0;
    end else begin
      cnt <= cnt_nxt;
      out <= out_nxt;
      if (rise) count_out <= count_out + 4'd1;
    end
  end

endmodule

// File: tb/tb_boton_antirrebote.sv
// Self-checking bench for boton_antirrebote (DEBOUNCE_CYCLES = 8).
module tb_boton_antirrebote;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_in;
  logic       out;
  logic [3:0] count_out;

  int tests = 0;
  int fails = 0;

  always #10 clk = ~clk;

  boton_antirrebote #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .out       (out),
    .count_out (count_out)
  );

  // Reference model: the filter at any edge sees the button level sampled
  // two edges earlier; out flips once the last D filter samples taken since
  // reset all disagree with it.
  logic       hist[$];
  logic       win[$];
  logic       m_out;
  logic [3:0] m_cnt;

  function automatic void model_reset();
    hist = '{1'b0, 1'b0};
    win.delete();
    m_out = 1'b0;
    m_cnt = 4'd0;
  endfunction

  function automatic void model_edge(input logic r, input logic b);
    logic fin;
    bit   all_diff;
    if (r) begin
      model_reset();
      return;
    end
    hist.push_back(b);
    fin = hist[hist.size()-3];
    if (hist.size() > 3) void'(hist.pop_front());
    win.push_back(fin);
    if (win.size() > D) void'(win.pop_front());
    all_diff = (win.size() == D);
    foreach (win[i]) if (win[i] == m_out) all_diff = 1'b0;
    if (all_diff) begin
      if (!m_out) m_cnt = m_cnt + 4'd1;
      m_out = ~m_out;
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge with the given inputs; DUT compared to the model after it.
  task automatic step(input logic r, input logic b);
    reset  = r;
    btn_in = b;
    @(posedge clk);
    model_edge(r, b);
    #1;
    check("model_out", int'(out), int'(m_out));
    check("model_cnt", int'(count_out), int'(m_cnt));
  endtask

  typedef struct {
    logic       rst;
    logic       btn;
    int         n;
    logic       e_out;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t vt[$];

  initial begin
    int k;
    bit seen;
    reset  = 1'b1;
    btn_in = 1'b0;
    model_reset();

    // Phase records: apply inputs for n edges, then expect the listed outputs.
    vt.push_back('{1'b1, 1'b1, 1,  1'b0, 4'd0});  // reset with btn toggling
    vt.push_back('{1'b1, 1'b0, 1,  1'b0, 4'd0});
    vt.push_back('{1'b1, 1'b1, 1,  1'b0, 4'd0});
    vt.push_back('{1'b0, 1'b0, 5,  1'b0, 4'd0});
    vt.push_back('{1'b0, 1'b1, 9,  1'b0, 4'd0});  // edges k..k+8: not yet
    vt.push_back('{1'b0, 1'b1, 1,  1'b1, 4'd1});  // edge k+9: rises
    vt.push_back('{1'b0, 1'b1, 15, 1'b1, 4'd1});  // held: no repeat
    vt.push_back('{1'b0, 1'b0, 9,  1'b1, 4'd1});
    vt.push_back('{1'b0, 1'b0, 1,  1'b0, 4'd1});  // release, count unchanged
    vt.push_back('{1'b0, 1'b1, 1,  1'b0, 4'd1});  // 1-cycle glitch
    vt.push_back('{1'b0, 1'b0, 10, 1'b0, 4'd1});
    vt.push_back('{1'b0, 1'b1, 5,  1'b0, 4'd1});  // 5-cycle glitch
    vt.push_back('{1'b0, 1'b0, 10, 1'b0, 4'd1});
    vt.push_back('{1'b0, 1'b1, 7,  1'b0, 4'd1});  // D-1 cycles: rejected
    vt.push_back('{1'b0, 1'b0, 12, 1'b0, 4'd1});
    vt.push_back('{1'b0, 1'b1, 8,  1'b0, 4'd1});  // exactly D cycles: accepted
    vt.push_back('{1'b0, 1'b0, 1,  1'b0, 4'd1});
    vt.push_back('{1'b0, 1'b0, 1,  1'b1, 4'd2});
    vt.push_back('{1'b0, 1'b0, 20, 1'b0, 4'd2});

    foreach (vt[i]) begin
      for (int c = 0; c < vt[i].n; c++) step(vt[i].rst, vt[i].btn);
      check($sformatf("vec%0d_out", i), int'(out), int'(vt[i].e_out));
      check($sformatf("vec%0d_cnt", i), int'(count_out), int'(vt[i].e_cnt));
    end

    // Bounce: toggles every 2 cycles, then held high; single rise on the
    // 10th edge counting the first stable-high sample.
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'b1); step(1'b0, 1'b1);
      step(1'b0, 1'b0); step(1'b0, 1'b0);
    end
    check("bounce_still_low", int'(out), 0);
    k = 0;
    seen = 0;
    while (!seen && k < 30) begin
      step(1'b0, 1'b1);
      k++;
      if (out) seen = 1;
    end
    check("bounce_rise_edges", k, D + 2);
    check("bounce_cnt", int'(count_out), 3);

    // Reset during a held press with out=1 and count_out=3.
    step(1'b0, 1'b1);
    check("pre_reset_out", int'(out), 1);
    step(1'b1, 1'b1);
    check("mid_reset_out", int'(out), 0);
    check("mid_reset_cnt", int'(count_out), 0);
    for (int c = 0; c < D + 1; c++) step(1'b0, 1'b1);
    check("rerise_early", int'(out), 0);
    step(1'b0, 1'b1);
    check("rerise_out", int'(out), 1);
    check("rerise_cnt", int'(count_out), 1);
    for (int c = 0; c < 15; c++) step(1'b0, 1'b0);

    // Wrap-around from a fresh reset: 17 presses, count 1..15, 0, 1.
    step(1'b1, 1'b0);
    for (int p = 1; p <= 17; p++) begin
      for (int c = 0; c < 15; c++) step(1'b0, 1'b1);
      check($sformatf("wrap_p%0d", p), int'(count_out), p % 16);
      for (int c = 0; c < 15; c++) step(1'b0, 1'b0);
    end
    check("wrap_final", int'(count_out), 1);

    // Randomised bursts with occasional resets, checked against the model.
    for (int b = 0; b < 400; b++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = (($urandom_range(0, 3) == 0) ? $urandom_range(D - 1, D + 2)
                                          : $urandom_range(1, 20));
      for (int c = 0; c < len; c++)
        step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, lvl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
